// File: rtl/mixer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mixer_pkg
//  Description : Shared types and constants for the harmonic mixer and other
//                rate-driven audio blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package mixer_pkg;

  // Widths of one harmonic word, of the accumulators/samples, and of the gain
  localparam int SAMPLE_W = 16;
  localparam int ACC_W    = 32;
  localparam int GAIN_W   = 8;

  // Default system clock and output sample rate
  localparam int CLK_HZ          = 96_000_000;
  localparam int SAMPLE_HZ       = 48_000;
  localparam int DEFAULT_DIVIDER = CLK_HZ / SAMPLE_HZ;

  // Mixer sequencing states
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ACCUM   = 3'd1,
    S_SCALE_L = 3'd2,
    S_SCALE_R = 3'd3,
    S_OUTPUT  = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sample_timebase.sv
`default_nettype none
// ============================================================================
//  Module      : sample_timebase
//  Description : Free-running divider producing a one-cycle tick once every
//                DIVIDER clock cycles (on the last count before wrap).
//  Revision    : 1.0 - initial release
// ============================================================================
module sample_timebase
  import mixer_pkg::*;
#(
  parameter int DIVIDER = DEFAULT_DIVIDER
) (
  input  logic i_Clock,
  input  logic i_Reset_N,
  output logic o_Tick
);

  localparam int            CW     = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(DIVIDER - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: wrap to zero after the last slot of the sample period
  always_comb begin
    cnt_d = (cnt_q == C_LAST) ? '0 : cnt_q + CW'(1);
  end

  // Counter register
  always_ff @(posedge i_Clock or negedge i_Reset_N) begin
    if (!i_Reset_N) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end

  assign o_Tick = (cnt_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/harmonic_mixer.sv
`default_nettype none
// ============================================================================
//  Module      : harmonic_mixer
//  Description : Accumulates per-harmonic words into L (odd) / R (even) sums,
//                applies a shared gain through one multiplier and hands the
//                stereo pair to the output stage once per sample period.
//  Revision    : 1.0 - initial release
// ============================================================================
module harmonic_mixer
  import mixer_pkg::*;
#(
  parameter int SAMPLE_DIVIDER = DEFAULT_DIVIDER,
  parameter int MAX_HARMONICS  = 64,
  parameter int GAIN_SHIFT     = 4
) (
  input  logic                       i_Clock,
  input  logic                       i_Reset_N,
  input  logic                       i_Harm_Valid,
  input  logic signed [SAMPLE_W-1:0] i_Harm_Sample,
  input  logic                       i_Harm_Odd,
  input  logic                       i_Harm_Last,
  output logic                       o_Harm_Ready,
  output logic                       o_Frame_Start,
  input  logic        [GAIN_W-1:0]   i_Gain,
  input  logic                       i_Out_Ready,
  output logic                       o_Start,
  output logic signed [ACC_W-1:0]    o_Sample_L,
  output logic signed [ACC_W-1:0]    o_Sample_R,
  output logic                       o_Overrun
);

  localparam int               CNT_W    = $clog2(MAX_HARMONICS + 1);
  localparam logic [CNT_W-1:0] C_MAX    = CNT_W'(MAX_HARMONICS);
  localparam logic [CNT_W-1:0] C_MAX_M1 = CNT_W'(MAX_HARMONICS - 1);

  state_t                    state_q, state_d;
  logic signed [ACC_W-1:0]   acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic signed [ACC_W-1:0]   result_l_q, result_l_d;
  logic signed [ACC_W-1:0]   sample_l_q, sample_l_d, sample_r_q, sample_r_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [GAIN_W-1:0]         gain_q, gain_d;
  logic                      start_q, start_d;
  logic                      frame_start_q, frame_start_d;
  logic                      overrun_q, overrun_d;

  logic                      w_tick;
  logic                      w_harm_ready;
  logic                      w_accept;
  logic signed [ACC_W-1:0]   w_word_ext;
  logic signed [ACC_W-1:0]   w_mul_a;
  logic        [GAIN_W-1:0]  w_mul_g;
  logic signed [ACC_W+GAIN_W:0] w_prod;
  logic signed [ACC_W-1:0]   w_scaled;

  sample_timebase #(
    .DIVIDER (SAMPLE_DIVIDER)
  ) u_timebase (
    .i_Clock   (i_Clock),
    .i_Reset_N (i_Reset_N),
    .o_Tick    (w_tick)
  );

  assign w_harm_ready = (state_q == S_ACCUM) && (count_q < C_MAX);
  assign w_accept     = i_Harm_Valid && w_harm_ready;
  assign w_word_ext   = ACC_W'(i_Harm_Sample);

  // The single multiplier: L uses the live gain (sampled now), R reuses it
  assign w_mul_a  = (state_q == S_SCALE_L) ? acc_l_q : acc_r_q;
  assign w_mul_g  = (state_q == S_SCALE_L) ? i_Gain  : gain_q;
  assign w_prod   = w_mul_a * $signed({1'b0, w_mul_g});
  assign w_scaled = ACC_W'(w_prod >>> GAIN_SHIFT);

  // Frame sequencing and datapath next-state
  always_comb begin
    state_d       = state_q;
    acc_l_d       = acc_l_q;
    acc_r_d       = acc_r_q;
    count_d       = count_q;
    gain_d        = gain_q;
    result_l_d    = result_l_q;
    sample_l_d    = sample_l_q;
    sample_r_d    = sample_r_q;
    start_d       = start_q;
    frame_start_d = 1'b0;
    overrun_d     = overrun_q;
    case (state_q)
      S_IDLE: begin
        if (w_tick) begin
          acc_l_d       = '0;
          acc_r_d       = '0;
          count_d       = '0;
          frame_start_d = 1'b1;
          state_d       = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (w_accept) begin
          if (i_Harm_Odd) acc_l_d = acc_l_q + w_word_ext;
          else            acc_r_d = acc_r_q + w_word_ext;
          count_d = count_q + CNT_W'(1);
        end
        // A word that completes the frame wins over a coincident tick
        if (w_accept && (i_Harm_Last || count_q == C_MAX_M1)) begin
          state_d = S_SCALE_L;
        end else if (w_tick) begin
          overrun_d = 1'b1;
          state_d   = S_SCALE_L;
        end
      end
      S_SCALE_L: begin
        gain_d     = i_Gain;
        result_l_d = w_scaled;
        state_d    = S_SCALE_R;
      end
      S_SCALE_R: begin
        sample_l_d = result_l_q;
        sample_r_d = w_scaled;
        start_d    = 1'b1;
        state_d    = S_OUTPUT;
      end
      S_OUTPUT: begin
        // Handshake wins over a coincident tick
        if (i_Out_Ready) begin
          start_d = 1'b0;
          state_d = S_IDLE;
        end else if (w_tick) begin
          start_d   = 1'b0;
          overrun_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge i_Clock or negedge i_Reset_N) begin
    if (!i_Reset_N) begin
      state_q       <= S_IDLE;
      acc_l_q       <= '0;
      acc_r_q       <= '0;
      count_q       <= '0;
      gain_q        <= '0;
      result_l_q    <= '0;
      sample_l_q    <= '0;
      sample_r_q    <= '0;
      start_q       <= 1'b0;
      frame_start_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_l_q       <= acc_l_d;
      acc_r_q       <= acc_r_d;
      count_q       <= count_d;
      gain_q        <= gain_d;
      result_l_q    <= result_l_d;
      sample_l_q    <= sample_l_d;
      sample_r_q    <= sample_r_d;
      start_q       <= start_d;
      frame_start_q <= frame_start_d;
      overrun_q     <= overrun_d;
    end
  end

  assign o_Harm_Ready  = w_harm_ready;
  assign o_Frame_Start = frame_start_q;
  assign o_Start       = start_q;
  assign o_Sample_L    = sample_l_q;
  assign o_Sample_R    = sample_r_q;
  assign o_Overrun     = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_harmonic_mixer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_harmonic_mixer
//  Description : Self-checking bench for harmonic_mixer (table, random and
//                corner-case frames against a sum-and-scale reference model).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_harmonic_mixer;

  localparam int DIV  = 200;
  localparam int MAXH = 64;
  localparam int GSH  = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               harm_valid, harm_odd, harm_last, out_ready;
  logic signed [15:0] harm_sample;
  logic        [7:0]  gain;
  logic               harm_ready, frame_start, start, overrun;
  logic signed [31:0] sample_l, sample_r;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  shortint wv[80];
  bit      wo[80];

  typedef struct {
    int         n;
    shortint    w[4];
    bit         odd[4];
    logic [7:0] g;
    int         eL;
    int         eR;
  } vec_t;
  vec_t tbl[4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  harmonic_mixer #(
    .SAMPLE_DIVIDER (DIV),
    .MAX_HARMONICS  (MAXH),
    .GAIN_SHIFT     (GSH)
  ) dut (
    .i_Clock       (clk),
    .i_Reset_N     (rst_n),
    .i_Harm_Valid  (harm_valid),
    .i_Harm_Sample (harm_sample),
    .i_Harm_Odd    (harm_odd),
    .i_Harm_Last   (harm_last),
    .o_Harm_Ready  (harm_ready),
    .o_Frame_Start (frame_start),
    .i_Gain        (gain),
    .i_Out_Ready   (out_ready),
    .o_Start       (start),
    .o_Sample_L    (sample_l),
    .o_Sample_R    (sample_r),
    .o_Overrun     (overrun)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: sum the words the mixer should take, then gain and shift
  function automatic void model(input int n, input bit use_last, input int g,
                                output int eL, output int eR, output int na);
    longint sl = 0, sr = 0;
    na = 0;
    for (int i = 0; i < n; i++) begin
      if (na == MAXH) break;
      na++;
      if (wo[i]) sl += wv[i];
      else       sr += wv[i];
      if (use_last && i == n - 1) break;
    end
    eL = int'((sl * g) >>> GSH);
    eR = int'((sr * g) >>> GSH);
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    harm_valid = 1'b0; harm_last = 1'b0; harm_odd = 1'b0; harm_sample = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_fs();
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!frame_start && t < 3 * DIV);
    chk("frame_start_seen", frame_start, 1);
  endtask

  // Wait for a frame, feed words (stop when ready drops), wait for o_Start
  task automatic run_frame(input int n, input bit use_last, input logic [7:0] g,
                           output int gl, output int gr, output int na,
                           output int lat, output int fcyc);
    int i = 0;
    int acc_cyc;
    int t = 0;
    gain = g;
    na = 0;
    wait_fs();
    fcyc = cyc;
    acc_cyc = cyc;
    while (i < n) begin
      harm_valid  = 1'b1;
      harm_sample = wv[i];
      harm_odd    = wo[i];
      harm_last   = use_last && (i == n - 1);
      if (!harm_ready) break;
      na++;
      acc_cyc = cyc;
      i++;
      @(negedge clk);
    end
    harm_valid = 1'b0;
    harm_last  = 1'b0;
    while (!start && t < 3 * DIV) begin
      @(negedge clk);
      t++;
    end
    chk("start_seen", start, 1);
    lat = cyc - acc_cyc;
    gl = sample_l;
    gr = sample_r;
  endtask

  initial begin
    int gl, gr, na, lat, fc, eL, eR, en, n, t, rc;

    tbl[0] = '{3, '{16'sd100, -16'sd50, 16'sd30, 16'sd0}, '{1'b1, 1'b0, 1'b1, 1'b0}, 8'd16, 130, -50};
    tbl[1] = '{1, '{-16'sd32768, 16'sd0, 16'sd0, 16'sd0}, '{1'b1, 1'b0, 1'b0, 1'b0}, 8'd32, -65536, 0};
    tbl[2] = '{3, '{16'sd1000, -16'sd2000, 16'sd7, 16'sd0}, '{1'b0, 1'b0, 1'b1, 1'b0}, 8'd255, 111, -15938};
    tbl[3] = '{2, '{16'sd500, 16'sd600, 16'sd0, 16'sd0}, '{1'b1, 1'b0, 1'b0, 1'b0}, 8'd0, 0, 0};

    out_ready = 1'b1;
    gain = 8'd16;
    rst_n = 1'b0;
    harm_valid = 1'b0; harm_last = 1'b0; harm_odd = 1'b0; harm_sample = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", harm_ready, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_start", start, 0);
    chk("rst_sample_l", sample_l, 0);
    chk("rst_sample_r", sample_r, 0);
    chk("rst_overrun", overrun, 0);
    rst_n = 1'b1;

    // Table-driven frames
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 4; i++) begin
        wv[i] = tbl[k].w[i];
        wo[i] = tbl[k].odd[i];
      end
      run_frame(tbl[k].n, 1'b1, tbl[k].g, gl, gr, na, lat, fc);
      chk("tbl_sample_l", gl, tbl[k].eL);
      chk("tbl_sample_r", gr, tbl[k].eR);
      chk("tbl_latency", lat, 3);
      chk("tbl_accepted", na, tbl[k].n);
      @(negedge clk);
      chk("tbl_start_drop", start, 0);
      chk("tbl_overrun", overrun, 0);
    end

    // Random frames against the model
    for (int k = 0; k < 6; k++) begin
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin
        wv[i] = shortint'($urandom);
        wo[i] = 1'($urandom);
      end
      gain = 8'($urandom);
      model(n, 1'b1, int'(gain), eL, eR, en);
      run_frame(n, 1'b1, gain, gl, gr, na, lat, fc);
      chk("rnd_sample_l", gl, eL);
      chk("rnd_sample_r", gr, eR);
      chk("rnd_latency", lat, 3);
      chk("rnd_accepted", na, en);
      @(negedge clk);
      chk("rnd_start_drop", start, 0);
    end

    // 70 words of +1, no last: capped at MAX_HARMONICS
    for (int i = 0; i < 70; i++) begin wv[i] = 16'sd1; wo[i] = 1'b1; end
    model(70, 1'b0, 16, eL, eR, en);
    run_frame(70, 1'b0, 8'd16, gl, gr, na, lat, fc);
    chk("cap_accepted", na, en);
    chk("cap_sample_l", gl, eL);
    chk("cap_sample_r", gr, 0);
    chk("cap_latency", lat, 3);
    chk("cap_overrun", overrun, 0);
    @(negedge clk);

    // Asynchronous reset in the middle of accumulation
    wait_fs();
    harm_valid = 1'b1; harm_sample = 16'sd9; harm_odd = 1'b1; harm_last = 1'b0;
    @(negedge clk);
    chk("mid_ready_before", harm_ready, 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", harm_ready, 0);
    chk("mid_rst_start", start, 0);
    chk("mid_rst_frame_start", frame_start, 0);
    chk("mid_rst_sample_l", sample_l, 0);
    chk("mid_rst_sample_r", sample_r, 0);
    chk("mid_rst_overrun", overrun, 0);
    harm_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rc = cyc;
    wait_fs();
    chk("release_to_frame", cyc - rc, DIV);
    do_reset();

    // Generator stalls after 5 words with no last: tick closes the frame
    for (int i = 0; i < 5; i++) begin wv[i] = shortint'(10 * (i + 1)); wo[i] = (i % 2 == 0); end
    model(5, 1'b0, 16, eL, eR, en);
    run_frame(5, 1'b0, 8'd16, gl, gr, na, lat, fc);
    chk("stall_sample_l", gl, eL);
    chk("stall_sample_r", gr, eR);
    chk("stall_overrun", overrun, 1);
    wait_fs();
    chk("stall_next_frame", cyc - fc, 2 * DIV);
    do_reset();

    // Output stage never ready: o_Start withdrawn at the next tick
    out_ready = 1'b0;
    wv[0] = 16'sd5; wo[0] = 1'b1;
    run_frame(1, 1'b1, 8'd16, gl, gr, na, lat, fc);
    chk("norr_sample_l", gl, 5);
    t = 0;
    while (start && t < 2 * DIV) begin
      @(negedge clk);
      t++;
    end
    chk("norr_drop_cycle", cyc - fc, DIV);
    chk("norr_overrun", overrun, 1);
    do_reset();

    // Handshake lands exactly on the tick cycle: clean handoff
    out_ready = 1'b0;
    wv[0] = -16'sd7; wo[0] = 1'b0;
    run_frame(1, 1'b1, 8'd16, gl, gr, na, lat, fc);
    chk("tickhs_sample_r", gr, -7);
    while (cyc < fc + DIV - 1) @(negedge clk);
    chk("tickhs_start_held", start, 1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("tickhs_start_drop", start, 0);
    chk("tickhs_overrun", overrun, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
